// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (instruction/data) to one memory port arbiter
//
// Shares one external memory port between the cpu instruction side and data
// side. Each side owns a one-deep pending slot. Only one memory transaction
// is outstanding at a time. Data has fixed priority, except that a starvation
// counter forces an instruction grant after STARVE_LIMIT consecutive losses.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   imem_valid/instr/addr/wdata/wstrb   instruction-side request
//   imem_rdata, imem_ready              instruction-side completion
//   dmem_*                              same as imem_*, data side
//   mem_valid/instr/addr/wdata/wstrb    issued request (valid is a 1-cycle pulse)
//   mem_rdata, mem_ready                memory completion

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic        imem_instr,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  input  logic [3:0]  imem_wstrb,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic        dmem_instr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  logic [1:0]  state;
  logic [3:0]  starve_cnt;

  logic        i_full, d_full;
  logic        i_instr, d_instr;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata;
  logic [3:0]  i_wstrb, d_wstrb;

  // Request held on the memory port from issue until completion.
  logic        h_instr;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_wstrb;

  logic        issue, grant_d, i_done, d_done;
  logic        win_instr;
  logic [31:0] win_addr, win_wdata;
  logic [3:0]  win_wstrb;

  assign issue   = (state == IDLE) && (i_full || d_full);
  assign grant_d = d_full && (!i_full || (starve_cnt != LIMIT));
  assign i_done  = (state == BUSY_I) && mem_ready;
  assign d_done  = (state == BUSY_D) && mem_ready;

  assign win_instr = grant_d ? d_instr : i_instr;
  assign win_addr  = grant_d ? d_addr  : i_addr;
  assign win_wdata = grant_d ? d_wdata : i_wdata;
  assign win_wstrb = grant_d ? d_wstrb : i_wstrb;

  // The issue cycle drives straight from the winning slot so a request
  // captured at cycle 0 reaches memory at cycle 1.
  always_comb begin
    mem_valid = issue;
    mem_instr = h_instr;
    mem_addr  = h_addr;
    mem_wdata = h_wdata;
    mem_wstrb = h_wstrb;
    if (issue) begin
      mem_instr = win_instr;
      mem_addr  = win_addr;
      mem_wdata = win_wdata;
      mem_wstrb = win_wstrb;
    end
  end

  assign imem_ready = i_done;
  assign dmem_ready = d_done;
  assign imem_rdata = i_done ? mem_rdata : 32'd0;
  assign dmem_rdata = d_done ? mem_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      i_full     <= 1'b0;
      d_full     <= 1'b0;
      i_instr    <= 1'b0;
      d_instr    <= 1'b0;
      i_addr     <= 32'd0;
      d_addr     <= 32'd0;
      i_wdata    <= 32'd0;
      d_wdata    <= 32'd0;
      i_wstrb    <= 4'd0;
      d_wstrb    <= 4'd0;
      h_instr    <= 1'b0;
      h_addr     <= 32'd0;
      h_wdata    <= 32'd0;
      h_wstrb    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state   <= grant_d ? BUSY_D : BUSY_I;
            h_instr <= win_instr;
            h_addr  <= win_addr;
            h_wdata <= win_wdata;
            h_wstrb <= win_wstrb;
            if (grant_d) begin
              if (i_full && (starve_cnt < LIMIT))
                starve_cnt <= starve_cnt + 4'd1;
            end else begin
              starve_cnt <= 4'd0;
            end
          end
        end
        BUSY_I:  if (mem_ready) state <= IDLE;
        BUSY_D:  if (mem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Completion frees the slot; a request arriving in that same cycle
      // is captured, so clear first and let capture override.
      if (i_done) i_full <= 1'b0;
      if (imem_valid && (!i_full || i_done)) begin
        i_full  <= 1'b1;
        i_instr <= imem_instr;
        i_addr  <= imem_addr;
        i_wdata <= imem_wdata;
        i_wstrb <= imem_wstrb;
      end

      if (d_done) d_full <= 1'b0;
      if (dmem_valid && (!d_full || d_done)) begin
        d_full  <= 1'b1;
        d_instr <= dmem_instr;
        d_addr  <= dmem_addr;
        d_wdata <= dmem_wdata;
        d_wstrb <= dmem_wstrb;
      end
    end
  end

  // A request presented while its slot is still occupied is dropped.
  ap_i_overrun: assert property (@(posedge clk) disable iff (!rst)
    !(imem_valid && i_full && !i_done));
  ap_d_overrun: assert property (@(posedge clk) disable iff (!rst)
    !(dmem_valid && d_full && !d_done));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_valid = 0, imem_instr = 0, dmem_valid = 0, dmem_instr = 0;
  logic [31:0] imem_addr = 0, imem_wdata = 0, dmem_addr = 0, dmem_wdata = 0;
  logic [3:0]  imem_wstrb = 0, dmem_wstrb = 0;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        imem_ready, dmem_ready;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 0;
  logic        mem_ready = 0;

  int errs = 0;
  int checks = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    go();
    go();
    smp();
    checks++; if (mem_valid !== 1'b0) begin errs++; $display("FAIL rst_mem_valid got=%b exp=0", mem_valid); end
    checks++; if (imem_ready !== 1'b0 || dmem_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got=%b%b exp=00", imem_ready, dmem_ready); end
    checks++; if (imem_rdata !== 32'd0 || dmem_rdata !== 32'd0) begin errs++; $display("FAIL rst_rdata got=%h/%h exp=0", imem_rdata, dmem_rdata); end
    checks++; if ({mem_instr, mem_addr, mem_wdata, mem_wstrb} !== 69'd0) begin errs++; $display("FAIL rst_mem_bus got=%b %h %h %h exp=0", mem_instr, mem_addr, mem_wdata, mem_wstrb); end
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    rst = 1'b1;
    go();
  endtask

  task automatic test_single_fetch();
    imem_valid = 1; imem_instr = 1; imem_addr = 32'h0000_0100; imem_wstrb = 0;
    smp();
    checks++; if (mem_valid !== 1'b0) begin errs++; $display("FAIL sf_c0_valid got=%b exp=0", mem_valid); end
    go();
    imem_valid = 0;
    smp();
    checks++; if (mem_valid !== 1'b1) begin errs++; $display("FAIL sf_issue got=%b exp=1", mem_valid); end
    checks++; if (mem_addr !== 32'h100 || mem_instr !== 1'b1) begin errs++; $display("FAIL sf_addr got=%h/%b exp=100/1", mem_addr, mem_instr); end
    go();
    smp();
    checks++; if (mem_valid !== 1'b0 || mem_addr !== 32'h100 || imem_ready !== 1'b0) begin errs++; $display("FAIL sf_wait got=%b/%h/%b exp=0/100/0", mem_valid, mem_addr, imem_ready); end
    go();
    mem_ready = 1; mem_rdata = 32'h0000_0013;
    smp();
    checks++; if (imem_ready !== 1'b1 || imem_rdata !== 32'h13) begin errs++; $display("FAIL sf_ready got=%b/%h exp=1/13", imem_ready, imem_rdata); end
    checks++; if (dmem_ready !== 1'b0 || dmem_rdata !== 32'd0) begin errs++; $display("FAIL sf_dside got=%b/%h exp=0/0", dmem_ready, dmem_rdata); end
    go();
    mem_ready = 0; mem_rdata = 0;
    smp();
    checks++; if (imem_ready !== 1'b0 || mem_valid !== 1'b0) begin errs++; $display("FAIL sf_after got=%b/%b exp=0/0", imem_ready, mem_valid); end
    go();
  endtask

  task automatic test_contention();
    imem_valid = 1; imem_instr = 1; imem_addr = 32'h200; imem_wstrb = 0;
    dmem_valid = 1; dmem_instr = 0; dmem_addr = 32'h8000_0000;
    dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
    go();
    imem_valid = 0; dmem_valid = 0;
    smp();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'hF) begin
      errs++; $display("FAIL ct_d_first got=%b %h %h %h exp=1 80000000 deadbeef f", mem_valid, mem_addr, mem_wdata, mem_wstrb); end
    go();
    mem_ready = 1;
    smp();
    checks++; if (dmem_ready !== 1'b1 || imem_ready !== 1'b0) begin errs++; $display("FAIL ct_d_ready got=%b%b exp=10", dmem_ready, imem_ready); end
    go();
    mem_ready = 0;
    smp();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h200 || mem_wstrb !== 4'h0) begin errs++; $display("FAIL ct_i_second got=%b %h %h exp=1 200 0", mem_valid, mem_addr, mem_wstrb); end
    go();
    mem_ready = 1; mem_rdata = 32'h55;
    smp();
    checks++; if (imem_ready !== 1'b1 || imem_rdata !== 32'h55) begin errs++; $display("FAIL ct_i_ready got=%b/%h exp=1/55", imem_ready, imem_rdata); end
    go();
    mem_ready = 0; mem_rdata = 0;
    go();
  endtask

  // D keeps re-requesting on every ready while I waits: after LIMIT data
  // grants the instruction side must win, then data priority resumes.
  task automatic test_starvation();
    imem_valid = 1; imem_instr = 1; imem_addr = 32'h300; imem_wstrb = 0;
    dmem_valid = 1; dmem_instr = 0; dmem_addr = 32'h1000; dmem_wstrb = 4'h3;
    go();
    imem_valid = 0; dmem_valid = 0;
    for (int k = 0; k < LIMIT; k++) begin
      smp();
      checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h1000 + 32'(k)) begin errs++; $display("FAIL sv_dgrant%0d got=%b/%h exp=1/%h", k, mem_valid, mem_addr, 32'h1000 + 32'(k)); end
      go();
      mem_ready = 1; dmem_valid = 1; dmem_addr = 32'h1000 + 32'(k + 1);
      smp();
      checks++; if (dmem_ready !== 1'b1) begin errs++; $display("FAIL sv_dready%0d got=%b exp=1", k, dmem_ready); end
      go();
      mem_ready = 0; dmem_valid = 0;
    end
    smp();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h300) begin errs++; $display("FAIL sv_igrant got=%b/%h exp=1/300", mem_valid, mem_addr); end
    go();
    mem_ready = 1;
    smp();
    checks++; if (imem_ready !== 1'b1) begin errs++; $display("FAIL sv_iready got=%b exp=1", imem_ready); end
    go();
    mem_ready = 0;
    smp();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h1000 + 32'(LIMIT)) begin errs++; $display("FAIL sv_dresume got=%b/%h exp=1/%h", mem_valid, mem_addr, 32'h1000 + 32'(LIMIT)); end
    go();
    mem_ready = 1;
    go();
    mem_ready = 0;
    go();
  endtask

  task automatic test_recapture();
    dmem_valid = 1; dmem_addr = 32'hA000_0040; dmem_wdata = 32'h1234_5678; dmem_wstrb = 4'h1;
    go();
    dmem_valid = 0;
    smp();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'hA000_0040) begin errs++; $display("FAIL rc_issue got=%b/%h exp=1/a0000040", mem_valid, mem_addr); end
    go();
    for (int w = 0; w < 10; w++) begin
      smp();
      checks++; if (mem_valid !== 1'b0 || mem_addr !== 32'hA000_0040 || mem_wdata !== 32'h1234_5678 || mem_wstrb !== 4'h1) begin
        errs++; $display("FAIL rc_hold%0d got=%b %h %h %h exp=0 a0000040 12345678 1", w, mem_valid, mem_addr, mem_wdata, mem_wstrb); end
      go();
    end
    mem_ready = 1; dmem_valid = 1; dmem_addr = 32'hB000_0080; dmem_wstrb = 0;
    smp();
    checks++; if (dmem_ready !== 1'b1) begin errs++; $display("FAIL rc_ready got=%b exp=1", dmem_ready); end
    go();
    mem_ready = 0; dmem_valid = 0;
    smp();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'hB000_0080) begin errs++; $display("FAIL rc_reissue got=%b/%h exp=1/b0000080", mem_valid, mem_addr); end
    go();
    mem_ready = 1;
    go();
    mem_ready = 0;
    go();
  endtask

  task automatic test_reset_midop();
    dmem_valid = 1; dmem_addr = 32'hC0; dmem_wstrb = 0;
    go();
    dmem_valid = 0;
    go();
    rst = 0;
    go();
    rst = 1;
    go();
    go();
    mem_ready = 1;
    smp();
    checks++; if (dmem_ready !== 1'b0 || imem_ready !== 1'b0 || mem_valid !== 1'b0) begin errs++; $display("FAIL rm_late_ready got=%b%b%b exp=000", dmem_ready, imem_ready, mem_valid); end
    go();
    mem_ready = 0;
    for (int w = 0; w < 3; w++) begin
      smp();
      checks++; if (mem_valid !== 1'b0) begin errs++; $display("FAIL rm_idle%0d got=%b exp=0", w, mem_valid); end
      go();
    end
  endtask

  task automatic test_spurious();
    mem_ready = 1; mem_rdata = 32'h9999_9999;
    smp();
    checks++; if (imem_ready !== 1'b0 || dmem_ready !== 1'b0 || imem_rdata !== 32'd0 || dmem_rdata !== 32'd0) begin
      errs++; $display("FAIL sp_ready got=%b%b %h %h exp=00 0 0", imem_ready, dmem_ready, imem_rdata, dmem_rdata); end
    go();
    mem_ready = 0;
    imem_valid = 1; imem_addr = 32'h400;
    smp();
    checks++; if (mem_valid !== 1'b0) begin errs++; $display("FAIL sp_novalid got=%b exp=0", mem_valid); end
    go();
    imem_valid = 0;
    smp();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h400) begin errs++; $display("FAIL sp_stillworks got=%b/%h exp=1/400", mem_valid, mem_addr); end
    go();
    mem_ready = 1;
    go();
    mem_ready = 0;
    go();
  endtask

  // Transaction-level model: a pending request per side, the owner of the
  // outstanding transaction and the count of data wins over a waiting fetch.
  task automatic test_random();
    bit          ip = 0, dp = 0;
    logic [68:0] ireq = '0, dreq = '0, held = '0, expb;
    int          owner = 0, scnt = 0, win;
    bit          mr, iv, dv, iss;
    logic [31:0] rd;

    rst = 0;
    go();
    rst = 1;
    for (int c = 0; c < 2000; c++) begin
      mr = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      rd = $urandom;
      iv = (!ip || (owner == 1 && mr)) && ($urandom_range(0, 1) == 1);
      dv = (!dp || (owner == 2 && mr)) && ($urandom_range(0, 1) == 1);
      mem_ready = mr; mem_rdata = rd;
      imem_valid = iv; imem_instr = 1'($urandom); imem_addr = $urandom; imem_wdata = $urandom; imem_wstrb = 4'($urandom);
      dmem_valid = dv; dmem_instr = 1'($urandom); dmem_addr = $urandom; dmem_wdata = $urandom; dmem_wstrb = 4'($urandom);

      iss = (owner == 0) && (ip || dp);
      win = (dp && (!ip || scnt != LIMIT)) ? 2 : 1;
      expb = iss ? ((win == 2) ? dreq : ireq) : held;

      smp();
      checks++; if (mem_valid !== iss) begin errs++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, mem_valid, iss); end
      if (iss || owner != 0) begin
        checks++; if ({mem_instr, mem_addr, mem_wdata, mem_wstrb} !== expb) begin
          errs++; $display("FAIL rnd_bus c=%0d got=%h exp=%h", c, {mem_instr, mem_addr, mem_wdata, mem_wstrb}, expb); end
      end
      checks++; if (imem_ready !== (owner == 1 && mr) || imem_rdata !== ((owner == 1 && mr) ? rd : 32'd0)) begin
        errs++; $display("FAIL rnd_iready c=%0d got=%b/%h exp=%b", c, imem_ready, imem_rdata, (owner == 1 && mr)); end
      checks++; if (dmem_ready !== (owner == 2 && mr) || dmem_rdata !== ((owner == 2 && mr) ? rd : 32'd0)) begin
        errs++; $display("FAIL rnd_dready c=%0d got=%b/%h exp=%b", c, dmem_ready, dmem_rdata, (owner == 2 && mr)); end

      if (iss) begin
        owner = win;
        held = expb;
        if (win == 1) scnt = 0;
        else if (ip && scnt < LIMIT) scnt++;
      end else if (owner != 0 && mr) begin
        if (owner == 1) ip = 0; else dp = 0;
        owner = 0;
      end
      if (iv) begin ip = 1; ireq = {imem_instr, imem_addr, imem_wdata, imem_wstrb}; end
      if (dv) begin dp = 1; dreq = {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb}; end
      go();
    end
    imem_valid = 0; dmem_valid = 0; mem_ready = 0;
    go();
  endtask

  initial begin
    go();
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_recapture();
    test_reset_midop();
    test_spurious();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
